// File: rtl/ram_arb_2p.sv
// ram_arb_2p: two-requester round-robin arbiter and sequencer for a single-port RAM.
// Each granted request takes one ACCESS cycle followed by a mandatory IDLE cycle.
// All RAM controls and client outputs come straight from registers, so nothing
// combinational connects req* to any output.
module ram_arb_2p #(
  parameter int DW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state_r, state_s;
  // ptr_r holds the last granted requester; during ACCESS it names the one being served.
  logic          ptr_r, ptr_s;
  logic          pick_s;
  logic          gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic          rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
  logic [DW-1:0] rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic          ram_wr_r, ram_wr_s, ram_rd_r, ram_rd_s;
  logic [AW-1:0] ram_add_r, ram_add_s;
  logic [DW-1:0] ram_din_r, ram_din_s;
  logic          busy_r, busy_s;

  // Next-state and next-output logic: arbitration in IDLE, completion in ACCESS.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    pick_s    = 1'b0;
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    rvalid0_s = 1'b0;
    rvalid1_s = 1'b0;
    rdata0_s  = rdata0_r;
    rdata1_s  = rdata1_r;
    ram_wr_s  = 1'b0;
    ram_rd_s  = 1'b0;
    ram_add_s = ram_add_r;
    ram_din_s = ram_din_r;
    busy_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          // Both requesting: the one that did not win last time goes next.
          if (req0 && req1) begin
            pick_s = ~ptr_r;
          end else if (req0) begin
            pick_s = 1'b0;
          end else begin
            pick_s = 1'b1;
          end
          if (pick_s == 1'b0) begin
            ram_wr_s  = we0;
            ram_rd_s  = ~we0;
            ram_add_s = addr0;
            ram_din_s = wdata0;
            gnt0_s    = 1'b1;
          end else begin
            ram_wr_s  = we1;
            ram_rd_s  = ~we1;
            ram_add_s = addr1;
            ram_din_s = wdata1;
            gnt1_s    = 1'b1;
          end
          busy_s  = 1'b1;
          ptr_s   = pick_s;
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        // The RAM drives ram_dout during a read ACCESS; capture it for the served requester.
        if (ram_rd_r) begin
          if (ptr_r == 1'b0) begin
            rdata0_s  = ram_dout;
            rvalid0_s = 1'b1;
          end else begin
            rdata1_s  = ram_dout;
            rvalid1_s = 1'b1;
          end
        end else begin
          rvalid0_s = 1'b0;
          rvalid1_s = 1'b0;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= 1'b1;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= {DW{1'b0}};
      rdata1_r  <= {DW{1'b0}};
      ram_wr_r  <= 1'b0;
      ram_rd_r  <= 1'b0;
      ram_add_r <= {AW{1'b0}};
      ram_din_r <= {DW{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      gnt0_r    <= gnt0_s;
      gnt1_r    <= gnt1_s;
      rvalid0_r <= rvalid0_s;
      rvalid1_r <= rvalid1_s;
      rdata0_r  <= rdata0_s;
      rdata1_r  <= rdata1_s;
      ram_wr_r  <= ram_wr_s;
      ram_rd_r  <= ram_rd_s;
      ram_add_r <= ram_add_s;
      ram_din_r <= ram_din_s;
      busy_r    <= busy_s;
    end
  end

  assign gnt0    = gnt0_r;
  assign gnt1    = gnt1_r;
  assign rvalid0 = rvalid0_r;
  assign rvalid1 = rvalid1_r;
  assign rdata0  = rdata0_r;
  assign rdata1  = rdata1_r;
  assign ram_wr  = ram_wr_r;
  assign ram_rd  = ram_rd_r;
  assign ram_add = ram_add_r;
  assign ram_din = ram_din_r;
  assign busy    = busy_r;

endmodule

// File: doc/ram_arb_2p.md
Name: ram_arb_2p

Overview:
Two-requester round-robin arbiter and sequencer for the team's small single-port RAM. The RAM has a synchronous write, a combinational read gated by rd, and tri-states its output when rd is low. The block serialises read/write requests from two masters onto the single RAM port, drives the RAM control/address/data lines from registers, and returns captured read data to the winning master with a one-cycle valid pulse. It sits between two client blocks and one RAM instance.

Parameters:
DW, 4, data width (RAM word width)
AW, 3, address width (passed through unchecked to RAM add)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 access request; held with we0/addr0/wdata0 stable until gnt0 sampled high
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  AW  requester 0 address
wdata0  input  DW  requester 0 write data
gnt0  output  1  high for exactly the ACCESS cycle serving requester 0
rvalid0  output  1  one-cycle pulse: rdata0 holds new read result
rdata0  output  DW  requester 0 read data, held until next read by requester 0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
ram_wr  output  1  to RAM wr
ram_rd  output  1  to RAM rd
ram_add  output  AW  to RAM add
ram_din  output  DW  to RAM data_in
ram_dout  input  DW  from RAM data_out (high-Z when ram_rd low)
busy  output  1  high while in ACCESS

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt0/1, rvalid0/1, ram_wr, ram_rd, busy = 0; ram_add, ram_din, rdata0/1 = 0; last-grant pointer = 1, so requester 0 wins first. Outputs clear immediately, not at the next edge. An access in flight is aborted: no write completes and no rvalid is issued.
- All outputs are registered; there is no combinational path from req* to any output.
- FSM, two states:
  - IDLE: outputs idle (ram_wr=ram_rd=0, gnt=0, busy=0). At a clock edge with any req high:
    - pick winner: the only requester if one; if both, the one != last-grant pointer.
    - latch winner's we/addr/wdata into ram_wr/ram_rd/ram_add/ram_din.
    - set gnt_winner=1, busy=1, pointer=winner, go to ACCESS.
  - ACCESS (exactly 1 cycle): RAM sees ram_wr=we, ram_rd=~we, ram_add, ram_din. At the edge ending ACCESS:
    - write: RAM stores the word.
    - read: rdata_winner<=ram_dout, rvalid_winner=1 for one cycle (the following IDLE cycle).
    - clear gnt, ram_wr, ram_rd, busy; go to IDLE.
- Latency: req sampled at edge N; ACCESS spans cycle N..N+1; rvalid high in cycle N+1..N+2. Read data is available two edges after the request edge.
- Throughput: at most one access per two cycles. The mandatory IDLE bubble lets the served requester drop req after sampling gnt.
- Requester rule: drop req (or present a new command) at the edge where gnt is sampled high. A req still high in IDLE is treated as a new request.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1. A single continuous requester is granted every other cycle.
- ram_add/ram_din hold their last values in IDLE; only ram_wr/ram_rd gate the RAM.
- rdata of the non-served requester is never modified.
- No address range checking. Addresses beyond RAM depth pass through unchanged.
- Read-after-write between requesters is ordered by grant order; a read granted after a write returns the written value.

Test Plan:
- Reset then idle: rst_n low mid-ACCESS with we0=1 -> ram_wr drops immediately, no rvalid; after release all outputs 0, busy 0.
- Single write/read, req0: write addr0=2 wdata0=4'hA, then read addr0=2 -> gnt0 one cycle each; ram_wr=1 only in the write ACCESS; rvalid0 pulses two edges after the read request with rdata0=4'hA; rdata1 unchanged at 0.
- Simultaneous first request: req0=req1=1 after reset -> gnt0 first, gnt1 next ACCESS (cycle N+2), ram_add tracks the respective addresses.
- Continuous contention: both req held high for 8 accesses, each dropping req at gnt -> grant sequence 0,1,0,1,...; busy toggles 1,0,1,0.
- Cross-requester coherency: req1 writes addr 1 = 4'h5, then req0 reads addr 1 -> rvalid0 with rdata0=4'h5; rvalid1 never asserted.
- Held req without drop: req0 held high 6 cycles, req1 low -> gnt0 on alternate cycles (3 accesses), never two consecutive ACCESS cycles.
